// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Entry fields are sized for the largest supported configuration
// (32 registers, up to 16 tracked slots); narrower ports are zero-extended.
package hazard_pkg;

  localparam int RV32E_NUM_REGS = 16;

  localparam int ENTRY_RD_W    = 5;
  localparam int ENTRY_AVAIL_W = 4;

  // First slot at which each kind of result exists.
  localparam int AVAIL_ALU  = 0;
  localparam int AVAIL_LOAD = 2;
  localparam int AVAIL_PC4  = 0;
  localparam int AVAIL_IMM  = 0;

  typedef struct packed {
    logic                     valid;
    logic [ENTRY_RD_W-1:0]    rd;
    logic [ENTRY_AVAIL_W-1:0] avail;
  } entry_t;

endpackage

// File: rtl/hazard_lookup.sv
// Single-operand lookup: finds the youngest in-flight writer of rs and
// decides whether its result can be forwarded yet. Purely combinational.
module hazard_lookup
  import hazard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  entry_t [DEPTH-1:0]      slots,
  input  logic [ENTRY_RD_W-1:0]   rs,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [DEPTH*XLEN-1:0]   stage_data,
  output logic [XLEN-1:0]         data,
  output logic                    fwd,
  output logic                    not_ready
);

  logic            hit;
  logic            ready;
  logic [XLEN-1:0] hit_data;

  // Walk from oldest to youngest so the youngest match overwrites older ones;
  // an older ready match is therefore shadowed by a younger unready one.
  always_comb begin
    hit      = 1'b0;
    ready    = 1'b0;
    hit_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].rd == rs) && (rs != '0)) begin
        hit      = 1'b1;
        ready    = (ENTRY_AVAIL_W'(k) >= slots[k].avail);
        hit_data = stage_data[k*XLEN +: XLEN];
      end
    end
  end

  assign fwd       = hit & ready;
  assign not_ready = hit & ~ready;
  assign data      = fwd ? hit_data : rf_data;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and operand forwarding for the in-order pipeline.
// Tracks every in-flight register writer downstream of ID in a shift
// register (slot 0 = EX, slot DEPTH-1 = WB) and supplies forwarded operands
// plus the ID stall. Optional macro HAZARD_PERF_EN adds stall/forward
// performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = RV32E_NUM_REGS,
  parameter int DEPTH       = 4,
  parameter int FLUSH_SLOTS = 1,
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [RW-1:0]         id_rs1,
  input  logic [RW-1:0]         id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RW-1:0]         id_rd,
  input  logic                  id_we,
  input  logic [AW-1:0]         id_avail,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  flush,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_fwd_events,
`endif
  output logic                  stall
);

  entry_t [DEPTH-1:0] slots;
  entry_t [DEPTH-1:0] slots_next;
  logic               rs1_not_ready;
  logic               rs2_not_ready;
  logic               issue;

  hazard_lookup #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lookup_rs1 (
    .slots      (slots),
    .rs         (ENTRY_RD_W'(id_rs1)),
    .rf_data    (rf_rs1_data),
    .stage_data (stage_data),
    .data       (rs1_data),
    .fwd        (rs1_fwd),
    .not_ready  (rs1_not_ready)
  );

  hazard_lookup #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lookup_rs2 (
    .slots      (slots),
    .rs         (ENTRY_RD_W'(id_rs2)),
    .rf_data    (rf_rs2_data),
    .stage_data (stage_data),
    .data       (rs2_data),
    .fwd        (rs2_fwd),
    .not_ready  (rs2_not_ready)
  );

  // A flush kills the instruction in ID, so it can never stall.
  assign stall = id_valid & ~flush &
                 ((id_rs1_used & rs1_not_ready) | (id_rs2_used & rs2_not_ready));

  // Only real, non-x0 writers that actually leave ID get tracked.
  assign issue = id_valid & id_we & (id_rd != '0) & ~stall & ~flush;

  // Next slot contents: new entry (or bubble) into slot 0, everything else
  // shifts one place; a flush invalidates the entries landing in the killed slots.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value held and infer a latch.
    slots_next          = '0;
    slots_next[0].valid = issue;
    slots_next[0].rd    = ENTRY_RD_W'(id_rd);
    slots_next[0].avail = ENTRY_AVAIL_W'(id_avail);
    for (int k = 1; k < DEPTH; k++) begin
      slots_next[k] = slots[k-1];
      if (flush && (k <= FLUSH_SLOTS)) begin
        slots_next[k].valid = 1'b0;
      end
    end
  end

  // Slot register; reset drops every in-flight entry at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, and this small
    // slot array is reset in full because stale valid bits would forward garbage.
    if (rst) begin
      slots <= '0;
    end else begin
      slots <= slots_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [1:0] fwd_count;

  assign fwd_count = {1'b0, rs1_fwd} + {1'b0, rs2_fwd};

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_fwd_events   <= '0;
    end else begin
      if (stall) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (id_valid && !stall) begin
        perf_fwd_events <= perf_fwd_events + 32'(fwd_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with fixed
// expectations, then randomized traffic against an instruction-list model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int XLEN        = 32;
  localparam int DEPTH       = 4;
  localparam int FLUSH_SLOTS = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  id_valid;
  logic [3:0]            id_rs1, id_rs2, id_rd;
  logic                  id_rs1_used, id_rs2_used, id_we;
  logic [1:0]            id_avail;
  logic [XLEN-1:0]       rf_rs1_data, rf_rs2_data;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic                  flush;
  logic [XLEN-1:0]       rs1_data, rs2_data;
  logic                  rs1_fwd, rs2_fwd, stall;
`ifdef HAZARD_PERF_EN
  logic [31:0]           perf_stall_cycles, perf_fwd_events;
`endif

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(
    .XLEN(XLEN), .NUM_REGS(16), .DEPTH(DEPTH), .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_avail    (id_avail),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .stage_data  (stage_data),
    .flush       (flush),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_fwd     (rs1_fwd),
    .rs2_fwd     (rs2_fwd),
`ifdef HAZARD_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fwd_events   (perf_fwd_events),
`endif
    .stall       (stall)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_we = 1'b0; id_rd = '0; id_avail = '0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue_writer(input logic [3:0] rd, input int avail);
    clear_id();
    id_valid = 1'b1; id_we = 1'b1; id_rd = rd; id_avail = 2'(avail);
  endtask

  task automatic idle(input int n);
    clear_id();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- behavioural reference model ----------------
  // In-flight writers are remembered by the cycle they left ID; their pipe
  // position is derived from elapsed time.
  typedef struct { int rd; int avail; int t; } wr_t;
  wr_t inflight[$];
  int  cyc;

  function automatic void model_lookup(input int rs, output bit hit, output bit ready,
                                       output int slot);
    int s;
    hit = 0; ready = 0; slot = 0;
    if (rs == 0) return;
    foreach (inflight[i]) begin
      s = cyc - inflight[i].t - 1;
      if (s >= 0 && s < DEPTH && inflight[i].rd == rs && (!hit || s < slot)) begin
        hit = 1; slot = s; ready = (s >= inflight[i].avail);
      end
    end
  endfunction

  function automatic void model_advance(input bit fl, input bit do_issue, input int rd,
                                        input int avail);
    int s;
    if (fl) begin
      for (int i = inflight.size() - 1; i >= 0; i--) begin
        s = cyc - inflight[i].t - 1;
        if (s + 1 >= 1 && s + 1 <= FLUSH_SLOTS) inflight.delete(i);
      end
    end
    if (do_issue) inflight.push_back('{rd: rd, avail: avail, t: cyc});
    cyc++;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (cyc - inflight[i].t - 1 >= DEPTH) inflight.delete(i);
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_id();
    rst = 1'b1;
    rf_rs1_data = 32'h1111_0001; rf_rs2_data = 32'h2222_0002;
    stage_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick(); tick();
    rst = 1'b0;
    id_valid = 1'b1; id_rs1 = 4'd1; id_rs2 = 4'd2; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (rs1_fwd !== 1'b0) begin errors++; $display("FAIL reset_rs1_fwd: got %b expected 0", rs1_fwd); end
    checks++; if (rs2_fwd !== 1'b0) begin errors++; $display("FAIL reset_rs2_fwd: got %b expected 0", rs2_fwd); end
    checks++; if (rs1_data !== 32'h1111_0001) begin errors++; $display("FAIL reset_rs1_data: got %h expected 11110001", rs1_data); end
    checks++; if (rs2_data !== 32'h2222_0002) begin errors++; $display("FAIL reset_rs2_data: got %h expected 22220002", rs2_data); end
`ifdef HAZARD_PERF_EN
    checks++; if (perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_cycles); end
    checks++; if (perf_fwd_events !== 32'd0) begin errors++; $display("FAIL reset_perf_fwd: got %0d expected 0", perf_fwd_events); end
`endif
    idle(1);
  endtask

  task automatic test_alu_forward();
    issue_writer(4'd1, AVAIL_ALU);
    tick();
    clear_id();
    id_valid = 1'b1; id_we = 1'b1; id_rd = 4'd2;
    id_rs1 = 4'd1; id_rs2 = 4'd1; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    rf_rs1_data = 32'hAAAA_AAAA; rf_rs2_data = 32'hBBBB_BBBB;
    stage_data = {32'hD3, 32'hD2, 32'hD1, 32'h55};
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", stall); end
    checks++; if (rs1_fwd !== 1'b1) begin errors++; $display("FAIL alu_rs1_fwd: got %b expected 1", rs1_fwd); end
    checks++; if (rs2_fwd !== 1'b1) begin errors++; $display("FAIL alu_rs2_fwd: got %b expected 1", rs2_fwd); end
    checks++; if (rs1_data !== 32'h55) begin errors++; $display("FAIL alu_rs1_data: got %h expected 55", rs1_data); end
    checks++; if (rs2_data !== 32'h55) begin errors++; $display("FAIL alu_rs2_data: got %h expected 55", rs2_data); end
    tick();
    idle(DEPTH);
  endtask

  task automatic test_load_use();
    issue_writer(4'd5, AVAIL_LOAD);
    tick();
    clear_id();
    id_valid = 1'b1; id_we = 1'b1; id_rd = 4'd6; id_rs1 = 4'd5; id_rs1_used = 1'b1;
    rf_rs1_data = 32'h0000_0BAD;
    stage_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall_c%0d: got %b expected 1", i, stall); end
      tick();
    end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b expected 0", stall); end
    checks++; if (rs1_fwd !== 1'b1) begin errors++; $display("FAIL load_use_fwd: got %b expected 1", rs1_fwd); end
    checks++; if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_use_data: got %h expected deadbeef", rs1_data); end
    tick();
    idle(DEPTH);
  endtask

  task automatic test_youngest();
    issue_writer(4'd3, AVAIL_ALU); tick();
    issue_writer(4'd3, AVAIL_ALU); tick();
    clear_id();
    id_valid = 1'b1; id_rs1 = 4'd3; id_rs1_used = 1'b1;
    stage_data = {32'h0, 32'h0, 32'h1, 32'h2};
    @(negedge clk);
    checks++; if (rs1_data !== 32'h2) begin errors++; $display("FAIL youngest_data: got %h expected 2", rs1_data); end
    checks++; if (rs1_fwd !== 1'b1) begin errors++; $display("FAIL youngest_fwd: got %b expected 1", rs1_fwd); end
    tick();
    idle(DEPTH);
    // Older ready ALU result is shadowed by a younger unready load.
    issue_writer(4'd7, AVAIL_ALU); tick();
    issue_writer(4'd7, AVAIL_LOAD); tick();
    clear_id();
    id_valid = 1'b1; id_rs2 = 4'd7; id_rs2_used = 1'b1;
    rf_rs2_data = 32'h7777_0000;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL shadow_stall: got %b expected 1", stall); end
    checks++; if (rs2_fwd !== 1'b0) begin errors++; $display("FAIL shadow_fwd: got %b expected 0", rs2_fwd); end
    idle(DEPTH);
  endtask

  task automatic test_x0();
    issue_writer(4'd0, AVAIL_ALU); tick();
    clear_id();
    id_valid = 1'b1; id_rs1 = 4'd0; id_rs1_used = 1'b1;
    rf_rs1_data = 32'h0;
    stage_data = '1;
    @(negedge clk);
    checks++; if (rs1_fwd !== 1'b0) begin errors++; $display("FAIL x0_fwd: got %b expected 0", rs1_fwd); end
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_data: got %h expected 0", rs1_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", stall); end
    idle(DEPTH);
  endtask

  task automatic test_flush();
    issue_writer(4'd4, AVAIL_LOAD); tick();
    clear_id();
    id_valid = 1'b1; id_rs1 = 4'd4; id_rs1_used = 1'b1;
    rf_rs1_data = 32'h1234_5678;
    stage_data = {32'hC3, 32'hC2, 32'hBAD, 32'hC0};
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b expected 1", stall); end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_next_stall: got %b expected 0", stall); end
    checks++; if (rs1_fwd !== 1'b0) begin errors++; $display("FAIL flush_next_fwd: got %b expected 0", rs1_fwd); end
    checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL flush_next_data: got %h expected 12345678", rs1_data); end
    idle(DEPTH);
  endtask

  task automatic test_back_to_back();
    // Old x9 reaches WB in the same cycle a new x9 issues.
    issue_writer(4'd9, AVAIL_ALU); tick();
    idle(3);
    issue_writer(4'd9, AVAIL_ALU);
    id_rs1 = 4'd9; id_rs1_used = 1'b1;
    stage_data = {32'h0000_0093, 32'h92, 32'h91, 32'h90};
    @(negedge clk);
    checks++; if (rs1_data !== 32'h93) begin errors++; $display("FAIL retire_wb_data: got %h expected 93", rs1_data); end
    tick();
    clear_id();
    id_valid = 1'b1; id_rs1 = 4'd9; id_rs1_used = 1'b1;
    stage_data = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    @(negedge clk);
    checks++; if (rs1_data !== 32'hE0) begin errors++; $display("FAIL retire_new_data: got %h expected e0", rs1_data); end
    checks++; if (rs1_fwd !== 1'b1) begin errors++; $display("FAIL retire_new_fwd: got %b expected 1", rs1_fwd); end
    idle(DEPTH);
  endtask

  task automatic test_reset_midflight();
    issue_writer(4'd8, AVAIL_LOAD); tick();
    clear_id();
    id_valid = 1'b1; id_rs1 = 4'd8; id_rs2 = 4'd8; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    rf_rs1_data = 32'h8888_0001; rf_rs2_data = 32'h8888_0002;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", stall); end
    checks++; if (rs1_fwd !== 1'b0) begin errors++; $display("FAIL midrst_rs1_fwd: got %b expected 0", rs1_fwd); end
    checks++; if (rs2_data !== 32'h8888_0002) begin errors++; $display("FAIL midrst_rs2_data: got %h expected 88880002", rs2_data); end
`ifdef HAZARD_PERF_EN
    checks++; if (perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL midrst_perf_stall: got %0d expected 0", perf_stall_cycles); end
    checks++; if (perf_fwd_events !== 32'd0) begin errors++; $display("FAIL midrst_perf_fwd: got %0d expected 0", perf_fwd_events); end
`endif
    idle(DEPTH);
  endtask

  task automatic test_random();
    bit h1, r1, h2, r2;
    int s1, s2;
    bit e_stall, e_f1, e_f2, e_issue;
    logic [XLEN-1:0] e_d1, e_d2;
    int exp_stall_cnt, exp_fwd_cnt;
    clear_id();
    rst = 1'b1; tick(); rst = 1'b0;
    inflight.delete();
    cyc = 0;
    exp_stall_cnt = 0; exp_fwd_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_we       = ($urandom_range(0, 3) != 0);
      id_rd       = 4'($urandom_range(0, 4));
      id_rs1      = 4'($urandom_range(0, 4));
      id_rs2      = 4'($urandom_range(0, 4));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_used = $urandom_range(0, 1) == 1;
      id_avail    = 2'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 7) == 0);
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      stage_data  = {$urandom, $urandom, $urandom, $urandom};

      model_lookup(int'(id_rs1), h1, r1, s1);
      model_lookup(int'(id_rs2), h2, r2, s2);
      e_f1 = h1 & r1;
      e_f2 = h2 & r2;
      e_d1 = e_f1 ? stage_data[s1*XLEN +: XLEN] : rf_rs1_data;
      e_d2 = e_f2 ? stage_data[s2*XLEN +: XLEN] : rf_rs2_data;
      e_stall = id_valid & ~flush & ((id_rs1_used & h1 & ~r1) | (id_rs2_used & h2 & ~r2));
      e_issue = id_valid & id_we & (id_rd != 0) & ~e_stall & ~flush;

      @(negedge clk);
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rand_stall@%0d: got %b expected %b", n, stall, e_stall); end
      checks++; if (rs1_fwd !== e_f1) begin errors++; $display("FAIL rand_rs1_fwd@%0d: got %b expected %b", n, rs1_fwd, e_f1); end
      checks++; if (rs2_fwd !== e_f2) begin errors++; $display("FAIL rand_rs2_fwd@%0d: got %b expected %b", n, rs2_fwd, e_f2); end
      checks++; if (rs1_data !== e_d1) begin errors++; $display("FAIL rand_rs1_data@%0d: got %h expected %h", n, rs1_data, e_d1); end
      checks++; if (rs2_data !== e_d2) begin errors++; $display("FAIL rand_rs2_data@%0d: got %h expected %h", n, rs2_data, e_d2); end

      if (e_stall) exp_stall_cnt++;
      if (id_valid && !e_stall) exp_fwd_cnt += int'(e_f1) + int'(e_f2);
      model_advance(flush, e_issue, int'(id_rd), int'(id_avail));
      tick();
    end
    clear_id();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    checks++; if (perf_stall_cycles !== 32'(exp_stall_cnt)) begin errors++; $display("FAIL rand_perf_stall: got %0d expected %0d", perf_stall_cycles, exp_stall_cnt); end
    checks++; if (perf_fwd_events !== 32'(exp_fwd_cnt)) begin errors++; $display("FAIL rand_perf_fwd: got %0d expected %0d", perf_fwd_events, exp_fwd_cnt); end
`endif
    idle(2);
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_x0();
    test_flush();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and operand-forwarding unit for the in-order RV32E pipeline; replaces the hand-wired per-stage compare chain and stall equation in the core top.
- Keeps a shift-register record of every in-flight register writer downstream of ID.
- Supplies forwarded rs1/rs2 operands to ID, and stalls ID only while the youngest matching producer's result is not yet available.
- Depth, register count, data width and per-instruction result latency are all configurable.

Parameters:
- XLEN, 32, datapath width.
- NUM_REGS, 16, architectural registers (16 for RV32E, 32 for RV32I).
- DEPTH, 4, tracked stages after ID; slot 0 = EX, slot DEPTH-1 = WB.
- FLUSH_SLOTS, 1, slots killed by flush, counted from slot 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  $clog2(NUM_REGS)  source register indices.
- id_rs1_used, id_rs2_used  in  1  the instruction actually reads that operand.
- id_rd  in  $clog2(NUM_REGS)  destination register.
- id_we  in  1  the instruction writes rd.
- id_avail  in  $clog2(DEPTH)  first slot at which the result exists (ALU 0, load 2, etc.).
- rf_rs1_data, rf_rs2_data  in  XLEN  regfile read data.
- stage_data  in  DEPTH*XLEN  slot k result at bits [k*XLEN +: XLEN], already muxed per rd_data_sel.
- flush  in  1  branch taken, resolved in EX.
- rs1_data, rs2_data  out  XLEN  operands to ID/EX.
- rs1_fwd, rs2_fwd  out  1  operand taken from stage_data.
- stall  out  1  hold IF and ID.

Behaviour:
- Entry fields: valid, rd, avail. Slots are registered; all lookup outputs are combinational from slot state plus the current inputs (zero added latency).
- Each cycle every slot shifts k -> k+1; slot DEPTH-1 retires.
- The regfile write of a retiring entry is visible to ID the following cycle.
- Slot 0 loads {id_valid & id_we & (id_rd != 0) & ~stall & ~flush, id_rd, id_avail}; otherwise it loads a bubble. Downstream slots never freeze.
- Flush: entries shifting into slots 1..FLUSH_SLOTS are invalidated, and slot 0 loads a bubble.
- Lookup per operand:
  - Find the youngest (lowest k) valid slot with rd == rs and rs != 0.
  - No match: data = rf data, fwd = 0.
  - Match with k >= avail: data = stage_data[k], fwd = 1.
  - Match with k < avail: operand not ready. Older matches are ignored even if they are ready.
- stall = id_valid & ~flush & ((id_rs1_used & rs1_not_ready) | (id_rs2_used & rs2_not_ready)).
- Register x0 never hazards and never forwards.
- Reset: all slots invalid; stall = 0, rs*_fwd = 0, rs*_data = rf data; counters = 0.
- Reset mid-operation discards all in-flight entries in the same cycle.
- Simultaneous flush and stall: flush wins and stall = 0.
- Simultaneous retire and issue to the same rd: the new entry is tracked and the retiring entry is ignored.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs, each 32 bits and wrapping at 2^32:
  - perf_stall_cycles: increments every cycle stall = 1.
  - perf_fwd_events: increments by rs1_fwd + rs2_fwd (0, 1 or 2) on cycles where id_valid & ~stall.
- Both counters clear on rst.
- When the macro is not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - the entry struct typedef (valid, rd, avail);
  - the RV32E NUM_REGS constant;
  - named avail constants: AVAIL_ALU=0, AVAIL_LOAD=2, AVAIL_PC4=0, AVAIL_IMM=0.
- One sub-module, hazard_lookup: youngest-match priority search plus ready check for one operand. It is instantiated twice, once each for rs1 and rs2.

Test Plan:
- Cycle 0: issue addi x1 (avail 0). Cycle 1: issue add x2,x1,x1 with stage_data slot0 = 0x55 -> stall=0, rs1_fwd=rs2_fwd=1, rs1_data=0x55.
- Issue lw x5 (avail 2), then a consumer of x5 -> stall=1 for exactly 2 cycles; on the third cycle rs1_data = slot2 data (0xDEAD_BEEF) and stall=0.
- Issue x3=1, then x3=2, then a reader of x3 -> the value from the younger slot (2) is forwarded, not 1.
- A writer with rd=0, then a reader of x0 -> rs1_fwd=0, rs1_data = rf_rs1_data (0), stall=0.
- lw x4 in slot 0, a reader of x4 stalled, flush=1 -> stall=0 that cycle; the next cycle slot 1 is empty and the reader gets rf data.
- Load in flight, then rst for 1 cycle -> the following cycle stall=0, fwd=0 for any rs; with HAZARD_PERF_EN both counters = 0.
